// File: rtl/block_sync_rx_ml.sv
// Multi-lane sync-header block lock receiver. Each lane hunts for a 2-bit
// sync header alignment by slipping its gearbox, then monitors header errors.
module block_sync_rx_ml #(
  parameter int LANE_N     = 4,
  parameter int HEAD_W     = 2,
  parameter int SH_CNT_MAX = 64,
  parameter int INVLD_MAX  = 16,
  parameter int SLIP_WAIT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N-1:0]        valid_i,
  input  logic [LANE_N-1:0]        head_v_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  output logic [LANE_N-1:0]        slip_v_o,
  output logic [LANE_N-1:0]        lock_v_o,
  output logic                     lock_all_o
);

  // state     | meaning
  // LOCK_INIT | signal not ok (or just reset); waiting for valid_i
  // TEST      | counting headers in the current test window
  // SLIP_HOLD | slip issued; headers ignored while the gearbox realigns

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int HOLD_W = (SLIP_WAIT > 2) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [CNT_W-1:0]  SH_LAST   = CNT_W'(SH_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  INV_LAST  = CNT_W'(INVLD_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'((SLIP_WAIT > 1) ? (SLIP_WAIT - 1) : 0);

  localparam logic [HEAD_W-1:0] HDR_DATA = HEAD_W'(2'b01);
  localparam logic [HEAD_W-1:0] HDR_CTRL = HEAD_W'(2'b10);

  generate
    if (SH_CNT_MAX < 2 || INVLD_MAX < 1 || INVLD_MAX > SH_CNT_MAX || LANE_N < 1) begin : g_bad_params
      $fatal(1, "block_sync_rx_ml: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST      = 2'd1,
    SLIP_HOLD = 2'd2
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < LANE_N; gi++) begin : g_lane
      state_t            r_state;
      state_t            w_state_nxt;
      logic [CNT_W-1:0]  r_sh_cnt;
      logic [CNT_W-1:0]  w_sh_cnt_nxt;
      logic [CNT_W-1:0]  r_invld_cnt;
      logic [CNT_W-1:0]  w_invld_cnt_nxt;
      logic [HOLD_W-1:0] r_hold_cnt;
      logic [HOLD_W-1:0] w_hold_cnt_nxt;
      logic              r_slip;
      logic              w_slip_nxt;
      logic              r_lock;
      logic              w_lock_nxt;
      logic [HEAD_W-1:0] w_hdr;
      logic              w_hdr_bad;
      logic              w_slip_req;

      assign w_hdr     = head_i[gi*HEAD_W +: HEAD_W];
      assign w_hdr_bad = !((w_hdr == HDR_DATA) || (w_hdr == HDR_CTRL));
      // Unlocked lanes slip on any bad header; locked lanes only when the
      // window's error budget is exhausted.
      assign w_slip_req = w_hdr_bad && (!r_lock || (r_invld_cnt == INV_LAST));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_state     <= LOCK_INIT;
          r_sh_cnt    <= '0;
          r_invld_cnt <= '0;
          r_hold_cnt  <= '0;
          r_slip      <= 1'b0;
          r_lock      <= 1'b0;
        end else begin
          r_state     <= w_state_nxt;
          r_sh_cnt    <= w_sh_cnt_nxt;
          r_invld_cnt <= w_invld_cnt_nxt;
          r_hold_cnt  <= w_hold_cnt_nxt;
          r_slip      <= w_slip_nxt;
          r_lock      <= w_lock_nxt;
        end
      end

      always_comb begin
        w_state_nxt     = r_state;
        w_sh_cnt_nxt    = r_sh_cnt;
        w_invld_cnt_nxt = r_invld_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_slip_nxt      = 1'b0;
        w_lock_nxt      = r_lock;

        if (!valid_i[gi]) begin
          w_state_nxt     = LOCK_INIT;
          w_sh_cnt_nxt    = '0;
          w_invld_cnt_nxt = '0;
          w_hold_cnt_nxt  = '0;
          w_lock_nxt      = 1'b0;
        end else begin
          case (r_state)
            LOCK_INIT: begin
              w_state_nxt = TEST;
            end
            TEST: begin
              if (head_v_i[gi]) begin
                if (w_slip_req) begin
                  w_state_nxt     = SLIP_HOLD;
                  w_slip_nxt      = 1'b1;
                  w_lock_nxt      = 1'b0;
                  w_sh_cnt_nxt    = '0;
                  w_invld_cnt_nxt = '0;
                  w_hold_cnt_nxt  = HOLD_INIT;
                end else if (r_sh_cnt == SH_LAST) begin
                  w_sh_cnt_nxt    = '0;
                  w_invld_cnt_nxt = '0;
                  w_lock_nxt      = 1'b1;
                end else begin
                  w_sh_cnt_nxt    = r_sh_cnt + CNT_W'(1);
                  w_invld_cnt_nxt = r_invld_cnt + CNT_W'(w_hdr_bad);
                end
              end
            end
            SLIP_HOLD: begin
              // The slip-pulse cycle is the first ignored cycle.
              if (r_hold_cnt == '0) begin
                w_state_nxt = TEST;
              end else begin
                w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
              end
            end
            default: begin
              w_state_nxt = LOCK_INIT;
            end
          endcase
        end
      end

      assign slip_v_o[gi] = r_slip;
      assign lock_v_o[gi] = r_lock;
    end
  endgenerate

  assign lock_all_o = &lock_v_o;

endmodule

// File: tb/tb_block_sync_rx_ml.sv
// Directed + randomized bench for block_sync_rx_ml, compared every cycle against
// a cycle-indexed behavioural model of the lock/slip rules.
module tb_block_sync_rx_ml;
  localparam int T_LN   = 4;
  localparam int T_HW   = 2;
  localparam int T_SHM  = 64;
  localparam int T_INV  = 16;
  localparam int T_SW   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [T_LN-1:0]        valid_i;
  logic [T_LN-1:0]        head_v_i;
  logic [T_LN*T_HW-1:0]   head_i;
  logic [T_LN-1:0]        slip_v_o;
  logic [T_LN-1:0]        lock_v_o;
  logic                   lock_all_o;

  block_sync_rx_ml #(
    .LANE_N(T_LN), .HEAD_W(T_HW), .SH_CNT_MAX(T_SHM), .INVLD_MAX(T_INV), .SLIP_WAIT(T_SW)
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .head_v_i(head_v_i), .head_i(head_i),
    .slip_v_o(slip_v_o), .lock_v_o(lock_v_o), .lock_all_o(lock_all_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: a lane is "live" once it has seen valid_i since the last drop/reset;
  // it counts headers only on cycles >= m_resume.
  int cyc = 0;
  bit m_live   [T_LN];
  int m_resume [T_LN];
  int m_sh     [T_LN];
  int m_inv    [T_LN];
  bit m_lock   [T_LN];
  bit m_slip   [T_LN];

  task automatic model_tick();
    for (int l = 0; l < T_LN; l++) begin
      logic [1:0] h;
      bit bad;
      h   = head_i[l*T_HW +: T_HW];
      bad = !(h == 2'b01 || h == 2'b10);
      m_slip[l] = 1'b0;
      if (reset || !valid_i[l]) begin
        m_live[l] = 1'b0; m_sh[l] = 0; m_inv[l] = 0; m_lock[l] = 1'b0;
      end else if (!m_live[l]) begin
        m_live[l] = 1'b1; m_resume[l] = cyc + 1;
      end else if (head_v_i[l] && cyc >= m_resume[l]) begin
        if (bad && (!m_lock[l] || m_inv[l] + 1 == T_INV)) begin
          m_slip[l] = 1'b1; m_lock[l] = 1'b0; m_sh[l] = 0; m_inv[l] = 0;
          m_resume[l] = cyc + 1 + ((T_SW > 1) ? T_SW : 1);
        end else begin
          m_sh[l]++;
          if (bad) m_inv[l]++;
          if (m_sh[l] == T_SHM) begin
            m_sh[l] = 0; m_inv[l] = 0; m_lock[l] = 1'b1;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic [T_LN-1:0] es, el;
    @(posedge clk);
    model_tick();
    #1;
    for (int l = 0; l < T_LN; l++) begin
      es[l] = m_slip[l];
      el[l] = m_lock[l];
    end
    check("slip_v_o", 32'(slip_v_o), 32'(es));
    check("lock_v_o", 32'(lock_v_o), 32'(el));
    check("lock_all_o", 32'(lock_all_o), 32'(&el));
  endtask

  // kind: 0 random valid header, 1 = 2'b11, 2 = 2'b00, 3 = any value
  function automatic logic [1:0] gen_hdr(input int kind);
    case (kind)
      0:       return 2'($urandom_range(1, 2));
      1:       return 2'b11;
      2:       return 2'b00;
      default: return 2'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic drive(input int l, input bit v, input bit hv, input int kind);
    valid_i[l]  = v;
    head_v_i[l] = hv;
    head_i[l*T_HW +: T_HW] = gen_hdr(kind);
  endtask

  initial begin
    int slip_t[$];
    int cnt;
    logic [T_LN-1:0] prev_lock;
    logic [T_LN-1:0] other_slip;
    bit all_seen;

    for (int l = 0; l < T_LN; l++) begin
      m_live[l] = 0; m_resume[l] = 0; m_sh[l] = 0; m_inv[l] = 0; m_lock[l] = 0; m_slip[l] = 0;
    end
    reset = 1'b1; valid_i = '0; head_v_i = '0; head_i = '0;
    repeat (3) step();
    check("reset_lock", 32'(lock_v_o), 32'h0);
    reset = 1'b0;

    // Lane 0 acquires lock with 64 valid headers after the entry cycle.
    drive(0, 1, 1, 0); step();
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 1, 0); step();
      if (i == 63) check("lock0_before_64", 32'(lock_v_o[0]), 32'h0);
      if (i == 64) check("lock0_at_64", 32'(lock_v_o[0]), 32'h1);
    end
    check("lock_all_one_lane", 32'(lock_all_o), 32'h0);

    // 15 invalid headers in a window: lock held.
    for (int i = 0; i < 64; i++) begin
      drive(0, 1, 1, (i % 4 == 1 && i < 60) ? 1 : 0); step();
    end
    check("lock0_15_invalid", 32'(lock_v_o[0]), 32'h1);
    // 16 invalid headers in a window: slip on the 16th.
    for (int i = 0; i < 46; i++) begin
      drive(0, 1, 1, (i % 3 == 0) ? 1 : 0); step();
      if (i == 42) check("lock0_15th_inv", 32'(lock_v_o[0]), 32'h1);
    end
    check("slip0_16th_inv", 32'(slip_v_o[0]), 32'h1);
    check("unlock0_16th_inv", 32'(lock_v_o[0]), 32'h0);

    // Lane 1: continuous 2'b00 -> slips every SLIP_WAIT+1 cycles.
    drive(1, 1, 1, 2); step();
    for (int i = 0; i < 15; i++) begin
      drive(0, 1, 1, 0); drive(1, 1, 1, 2); step();
      if (slip_v_o[1]) slip_t.push_back(cyc);
    end
    check("slip1_count", 32'(slip_t.size() >= 4), 32'h1);
    for (int k = 1; k < slip_t.size(); k++)
      check("slip1_spacing", 32'(slip_t[k] - slip_t[k-1]), 32'(T_SW + 1));
    drive(1, 0, 0, 0);

    // Relock lane 0, drop valid_i for one cycle, relock after 64 more headers.
    for (int i = 0; i < 70; i++) begin drive(0, 1, 1, 0); step(); end
    check("lock0_relock", 32'(lock_v_o[0]), 32'h1);
    drive(0, 0, 1, 0); step();
    check("lock0_drop", 32'(lock_v_o[0]), 32'h0);
    check("slip0_drop", 32'(slip_v_o[0]), 32'h0);
    drive(0, 1, 1, 0); step();
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 1, 0); step();
      if (i == 63) check("lock0_drop_63", 32'(lock_v_o[0]), 32'h0);
    end
    check("lock0_drop_64", 32'(lock_v_o[0]), 32'h1);

    // Staggered start on lanes 1..3; lock_all rises with the last lane.
    all_seen = 0;
    for (int i = 0; i < 90; i++) begin
      drive(0, 1, 1, 0);
      drive(1, i >= 0, 1, 0);
      drive(2, i >= 5, 1, 0);
      drive(3, i >= 11, 1, 0);
      prev_lock = lock_v_o;
      step();
      if (lock_all_o && !all_seen) begin
        all_seen = 1;
        check("all_rise_prev3", 32'(prev_lock[3]), 32'h0);
        check("all_rise_vec", 32'(lock_v_o), 32'hF);
      end
    end
    check("all_locked", 32'(all_seen), 32'h1);
    // Invalid burst on lane 2 only.
    other_slip = '0;
    for (int i = 0; i < 24; i++) begin
      for (int l = 0; l < T_LN; l++) drive(l, 1, 1, (l == 2 && i < 20) ? 1 : 0);
      step();
      other_slip |= slip_v_o & 4'b1011;
    end
    check("burst_other_slip", 32'(other_slip), 32'h0);
    check("burst_lock_vec", 32'(lock_v_o), 32'hB);

    // Reset, then 50% header strobe during acquisition.
    reset = 1'b1; step(); step(); reset = 1'b0;
    for (int l = 0; l < T_LN; l++) drive(l, 1, 1, 0);
    step();
    cnt = 0;
    while (cnt < 64) begin
      for (int l = 0; l < T_LN; l++) drive(l, 1, 1'($urandom_range(0, 1)), 0);
      if (head_v_i[0]) cnt++;
      step();
      check("lock0_strobe50", 32'(lock_v_o[0]), 32'(cnt >= 64));
    end
    // Reset mid-window (lane 1 also mid slip hold) discards progress.
    for (int i = 0; i < 64; i++) begin drive(0, 1, 1, 0); drive(1, 1, 1, 0); step(); end
    for (int i = 0; i < 30; i++) begin drive(0, 1, 1, 0); drive(1, 1, 1, 3); step(); end
    drive(1, 1, 1, 1); step();
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_mid_lock", 32'(lock_v_o), 32'h0);
    drive(0, 1, 1, 0); step();
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 1, 0); step();
      if (i == 63) check("lock0_after_rst_63", 32'(lock_v_o[0]), 32'h0);
    end
    check("lock0_after_rst_64", 32'(lock_v_o[0]), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 1499) == 0);
      for (int l = 0; l < T_LN; l++)
        drive(l, ($urandom_range(0, 299) != 0), 1'($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 3 : 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/block_sync_rx_ml.md
BLOCK_SYNC_RX_ML -- requirements
Module: block_sync_rx_ml

Interface
REQ-001 SHALL have parameter LANE_N, default 4, number of independent lanes.
REQ-002 SHALL have parameter HEAD_W, default 2, sync header width per lane.
REQ-003 SHALL have parameter SH_CNT_MAX, default 64, headers per test window.
REQ-004 SHALL have parameter INVLD_MAX, default 16, invalid headers per window that cause loss of lock.
REQ-005 SHALL have parameter SLIP_WAIT, default 2, cycles a lane ignores headers after each slip.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port valid_i  input  LANE_N  per-lane signal_ok.
REQ-009 SHALL have port head_v_i  input  LANE_N  per-lane header strobe; head_i is sampled only when set.
REQ-010 SHALL have port head_i  input  LANE_N*HEAD_W  lane n header at bits [n*HEAD_W +: HEAD_W].
REQ-011 SHALL have port slip_v_o  output  LANE_N  per-lane one-cycle slip request to gearbox.
REQ-012 SHALL have port lock_v_o  output  LANE_N  per-lane rx_block_lock.
REQ-013 SHALL have port lock_all_o  output  1  all lanes locked.

Function
REQ-014 Each lane SHALL run an identical, independent FSM with states LOCK_INIT, TEST, SLIP_HOLD, plus counters sh_cnt and invld_cnt, each $clog2(SH_CNT_MAX+1) bits wide.
REQ-015 A header SHALL be valid iff its value is 2'b01 (data) or 2'b10 (control); 2'b00 and 2'b11 SHALL be invalid.
REQ-016 A header SHALL be counted only when valid_i[n]=1, head_v_i[n]=1, and the lane is in TEST.
REQ-017 In TEST, each counted header SHALL increment sh_cnt; each counted invalid header SHALL also increment invld_cnt.
REQ-018 Unlocked lane, invalid header: the next cycle SHALL assert slip_v_o[n] for exactly one cycle, clear both counters, and enter SLIP_HOLD.
REQ-019 Locked lane, invalid header with invld_cnt+1 = INVLD_MAX: the next cycle SHALL assert slip_v_o[n] for one cycle, deassert lock_v_o[n], clear both counters, and enter SLIP_HOLD.
REQ-020 Counted header with sh_cnt+1 = SH_CNT_MAX and no slip: both counters SHALL clear; an unlocked lane SHALL set lock_v_o[n]=1 the next cycle; a locked lane SHALL stay locked.
REQ-021 If REQ-019 and REQ-020 coincide on the same header, the slip SHALL take priority.
REQ-022 In SLIP_HOLD, the lane SHALL ignore head_v_i for SLIP_WAIT cycles, counted from the cycle slip_v_o is high, then return to TEST.
REQ-023 With SLIP_WAIT=0, the lane SHALL return to TEST the cycle after slip_v_o.
REQ-024 valid_i[n]=0 in any state SHALL force LOCK_INIT the next cycle: lock_v_o[n]=0, slip_v_o[n]=0, counters cleared, any SLIP_HOLD countdown cancelled.
REQ-025 LOCK_INIT SHALL move to TEST on the first cycle valid_i[n]=1; a header presented in that cycle SHALL NOT be counted.
REQ-026 slip_v_o and lock_v_o SHALL be registered outputs.
REQ-027 lock_all_o SHALL be the combinational AND of lock_v_o.
REQ-028 Lanes SHALL NOT influence each other except through lock_all_o.
REQ-029 Elaboration SHALL fail if SH_CNT_MAX<2, INVLD_MAX<1, INVLD_MAX>SH_CNT_MAX, or LANE_N<1.

Reset
REQ-030 While reset=1, at each clock edge: all lanes SHALL enter LOCK_INIT with counters 0, slip_v_o=0, lock_v_o=0, lock_all_o=0.
REQ-031 Reset asserted mid-window or during SLIP_HOLD SHALL discard all progress; after reset deasserts, a lane SHALL need REQ-025 plus SH_CNT_MAX valid headers to lock.

Verification
REQ-032 Defaults; lane 0 valid_i=1, 64 strobed valid headers -> lock_v_o[0]=1 the cycle after the 64th, slip_v_o[0] never high, lock_all_o=0.
REQ-033 Locked lane, then 16 invalid headers (2'b11) interleaved with valid ones inside one 64-header window -> slip pulse and lock_v_o=0 the cycle after the 16th invalid; 15 invalid in a window -> lock held and counters restart.
REQ-034 Unlocked lane, continuous 2'b00 headers every cycle -> one slip pulse, then SLIP_WAIT=2 ignored cycles, then the next slip; slip spacing is exactly 3 cycles.
REQ-035 Locked lane, valid_i drops for 1 cycle -> lock_v_o=0 the next cycle, no slip; relock only after 64 more valid headers.
REQ-036 All 4 lanes locked with staggered start -> lock_all_o rises the same cycle the last lane locks; an invalid burst on lane 2 only -> only slip_v_o[2] pulses, and lock_all_o falls with lock_v_o[2].
REQ-037 head_v_i toggling 50% during lock acquisition -> lock after exactly 64 strobed headers; reset mid-window clears progress.
